download_tx: RTL and testbench
==============================

DOWNLOAD_TX -- requirements
Module: download_tx

Interface
REQ-001 Parameter CLOCK_RATE, default 25175000, clock frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 9600, UART bit rate; BAUD_DIV = CLOCK_RATE/BAUD_RATE, integer floor (2622 at defaults); BAUD_DIV >= 2 SHALL hold.
REQ-003 clk  input  1  clock.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 clk_enable  input  1  when low, all internal state, counters and outputs SHALL hold.
REQ-006 start  input  1  one-cycle request to begin a dump.
REQ-007 length  input  16  number of data bytes N, sampled when start is accepted.
REQ-008 rd_data  input  8  memory read data, valid on the enabled cycle after re.
REQ-009 re  output  1  memory read strobe, one enabled cycle per data byte.
REQ-010 addr  output  32  byte address being read.
REQ-011 tx  output  1  UART 8N1 serial line, idle high.
REQ-012 busy  output  1  dump in progress.
REQ-013 done  output  1  sticky: dump finished.

Function
REQ-014 All state advances only on rising clk edges with clk_enable=1; "cycle" below means enabled cycle.
REQ-015 FSM states: IDLE, LOAD, LATCH, SEND, FINISH.
REQ-016 IDLE: start=1 -> capture length into a 16-bit count, set addr=0, clear done, busy=1, go to LOAD with byte index = header-high.
REQ-017 start SHALL be ignored while busy=1.
REQ-018 Byte order on tx: length[15:8], length[7:0], then memory bytes addr 0..N-1.
REQ-019 LOAD (1 cycle): for a header byte, re=0; for a data byte, re=1 with addr stable.
REQ-020 LATCH (1 cycle): shift register loaded with header byte or rd_data; re=0.
REQ-021 SEND: frame = start bit 0, data bits LSB first, stop bit 1; each bit held exactly BAUD_DIV cycles (10*BAUD_DIV cycles per frame).
REQ-022 tx SHALL be high in IDLE, LOAD, LATCH and FINISH, giving exactly 2 idle-high cycles between consecutive frames.
REQ-023 End of stop bit: if bytes remain -> LOAD; else -> FINISH.
REQ-024 addr SHALL increment by 1 (32-bit wrap) at the end of each data-byte LATCH; after a full dump addr = N.
REQ-025 Header bytes SHALL NOT consume count or change addr.
REQ-026 N=0: transmit 0x00 0x00, no re pulse, then FINISH.
REQ-027 N=65535: full 16-bit count SHALL be handled without overflow; 65535 data frames sent.
REQ-028 FINISH (1 cycle): busy=0, done=1, -> IDLE; done stays 1 until next accepted start or reset.
REQ-029 clk_enable low mid-frame SHALL stretch the current bit; addr held so rd_data stays valid for LATCH.
REQ-030 re SHALL be high only when state=LOAD, data byte, and clk_enable=1.

Reset
REQ-031 reset=1 SHALL force IDLE, tx=1, re=0, busy=0, done=0, addr=0, count=0, baud and bit counters=0, regardless of clk_enable.
REQ-032 Reset mid-frame SHALL truncate the frame; tx high from the cycle after reset is sampled.
REQ-033 After reset release, block idle until next start.

Verification (CLOCK_RATE=16, BAUD_RATE=1, BAUD_DIV=16, clk_enable=1 unless stated)
REQ-034 start, length=2, mem[0]=0xA5, mem[1]=0x3C -> tx frames 0x00,0x02,0xA5,0x3C, 160 cycles each, 2 idle cycles between; re pulses at addr 0 and 1; done=1, addr=2.
REQ-035 start, length=0 -> frames 0x00,0x00 only, re never asserted, done=1, addr=0.
REQ-036 start again during busy with length=5 -> ignored; original dump completes unchanged.
REQ-037 clk_enable toggled 1/0 every cycle, length=1, mem[0]=0x81 -> same bit sequence, each bit 32 clocks wide.
REQ-038 reset during third bit of header-low frame -> next cycle tx=1, busy=0, done=0, addr=0; new start, length=1 runs cleanly.
REQ-039 Loopback to the existing upload receiver, length=4, random bytes -> receiver writes identical bytes to addr 0..3 and asserts complete.

Source files
------------

// File: rtl/download_tx.sv
// UART 8N1 memory dump transmitter: sends a 16-bit length header (high byte
// first) followed by N bytes read from memory starting at address 0.
module download_tx #(
    parameter int unsigned CLOCK_RATE = 25175000,
    parameter int unsigned BAUD_RATE  = 9600
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_enable,
    input  logic        start,
    input  logic [15:0] length,
    input  logic [7:0]  rd_data,
    output logic        re,
    output logic [31:0] addr,
    output logic        tx,
    output logic        busy,
    output logic        done
);

    localparam int unsigned BAUD_DIV = CLOCK_RATE / BAUD_RATE;
    localparam int unsigned BW       = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        LATCH,
        SEND,
        FINISH
    } state_t;

    typedef enum logic [1:0] {
        HDR_HI,
        HDR_LO,
        DATA
    } phase_t;

    state_t        state_q, state_d;
    phase_t        phase_q, phase_d;
    logic [15:0]   count_q, count_d;
    logic [31:0]   addr_q,  addr_d;
    logic [7:0]    shift_q, shift_d;
    logic [3:0]    bit_q,   bit_d;
    logic [BW-1:0] baud_q,  baud_d;
    logic          done_q,  done_d;
    logic [9:0]    frame;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            phase_q <= HDR_HI;
            count_q <= '0;
            addr_q  <= '0;
            shift_q <= '0;
            bit_q   <= '0;
            baud_q  <= '0;
            done_q  <= 1'b0;
        end else if (clk_enable) begin
            state_q <= state_d;
            phase_q <= phase_d;
            count_q <= count_d;
            addr_q  <= addr_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
            baud_q  <= baud_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        count_d = count_q;
        addr_d  = addr_q;
        shift_d = shift_q;
        bit_d   = bit_q;
        baud_d  = baud_q;
        done_d  = done_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    count_d = length;
                    addr_d  = '0;
                    done_d  = 1'b0;
                    phase_d = HDR_HI;
                    state_d = LOAD;
                end
            end
            LOAD: state_d = LATCH;
            LATCH: begin
                // count_q still holds the full length while headers are sent
                case (phase_q)
                    HDR_HI:  shift_d = count_q[15:8];
                    HDR_LO:  shift_d = count_q[7:0];
                    default: begin
                        shift_d = rd_data;
                        addr_d  = addr_q + 32'd1;
                        count_d = count_q - 16'd1;
                    end
                endcase
                baud_d  = '0;
                bit_d   = '0;
                state_d = SEND;
            end
            SEND: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d = '0;
                    if (bit_q == 4'd9) begin
                        if (phase_q == HDR_HI) begin
                            phase_d = HDR_LO;
                            state_d = LOAD;
                        end else if (count_q != 16'd0) begin
                            phase_d = DATA;
                            state_d = LOAD;
                        end else begin
                            done_d  = 1'b1;
                            state_d = FINISH;
                        end
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            FINISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign frame = {1'b1, shift_q, 1'b0};
    assign tx    = (state_q == SEND) ? frame[bit_q] : 1'b1;
    assign re    = (state_q == LOAD) && (phase_q == DATA) && clk_enable;
    assign busy  = (state_q == LOAD) || (state_q == LATCH) || (state_q == SEND);
    assign addr  = addr_q;
    assign done  = done_q;

endmodule

// File: tb/tb_download_tx.sv
// Bench for download_tx: a cycle-level expectation queue built from the byte
// stream and frame timing, compared against the DUT on every clock.
module tb_download_tx;

    localparam int unsigned BD = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        clk_enable;
    logic        start;
    logic [15:0] length;
    logic [7:0]  rd_data = '0;
    logic        re;
    logic [31:0] addr;
    logic        tx;
    logic        busy;
    logic        done;

    logic [7:0] mem [16];
    bit         tog = 1'b0;

    int checks = 0;
    int errors = 0;
    int re_cnt = 0;
    int busy_cnt = 0;
    int low_run = 0;
    int runs[$];

    typedef struct packed {
        logic        tx;
        logic        re_l;
        logic        busy;
        logic        done;
        logic        idle;
        logic [31:0] addr;
    } exp_t;

    exp_t q[$];
    exp_t cur;

    download_tx #(.CLOCK_RATE(16), .BAUD_RATE(1)) dut (
        .clk(clk),
        .reset(reset),
        .clk_enable(clk_enable),
        .start(start),
        .length(length),
        .rd_data(rd_data),
        .re(re),
        .addr(addr),
        .tx(tx),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    // memory with one-cycle read latency
    always @(posedge clk) if (re) rd_data <= mem[addr[3:0]];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic t, input logic r, input logic b,
                                input logic d, input logic i, input logic [31:0] a);
        exp_t e;
        e.tx = t; e.re_l = r; e.busy = b; e.done = d; e.idle = i; e.addr = a;
        return e;
    endfunction

    task automatic build(input logic [15:0] n);
        logic [7:0]  b;
        logic [15:0] nn;
        logic        bv;
        logic [31:0] a;
        nn = n;
        for (int k = 0; k < int'(nn) + 2; k++) begin
            if (k == 0)      b = nn[15:8];
            else if (k == 1) b = nn[7:0];
            else             b = mem[k - 2];
            a = (k >= 2) ? 32'(k - 2) : 32'd0;
            q.push_back(mk(1'b1, k >= 2, 1'b1, 1'b0, 1'b0, a));
            q.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, a));
            if (k >= 2) a = a + 32'd1;
            for (int bi = 0; bi < 10; bi++) begin
                if (bi == 0)      bv = 1'b0;
                else if (bi == 9) bv = 1'b1;
                else              bv = b[bi - 1];
                for (int c = 0; c < int'(BD); c++)
                    q.push_back(mk(bv, 1'b0, 1'b1, 1'b0, 1'b0, a));
            end
        end
        q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, {16'd0, nn}));
    endtask

    initial begin
        cur = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0);
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                q.delete();
                cur = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0);
            end else if (clk_enable) begin
                if (cur.idle && start) begin
                    build(length);
                    cur = q.pop_front();
                end else if (q.size() > 0) begin
                    cur = q.pop_front();
                end else begin
                    cur.idle = 1'b1; cur.tx = 1'b1; cur.re_l = 1'b0; cur.busy = 1'b0;
                end
            end
            chk("tx",   tx,   cur.tx);
            chk("re",   re,   cur.re_l & clk_enable);
            chk("busy", busy, cur.busy);
            chk("done", done, cur.done);
            chk("addr", addr, cur.addr);
            if (re === 1'b1 && clk_enable) re_cnt++;
            if (busy === 1'b1 && clk_enable) busy_cnt++;
            if (tx === 1'b0) low_run++;
            else if (low_run > 0) begin
                runs.push_back(low_run);
                low_run = 0;
            end
        end
    end

    task automatic step();
        @(negedge clk);
        if (tog) clk_enable = ~clk_enable;
        else     clk_enable = 1'b1;
    endtask

    task automatic pulse_start(input logic [15:0] n);
        while (clk_enable !== 1'b1) step();
        length = n;
        start  = 1'b1;
        step();
        start  = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (!(done === 1'b1 && busy === 1'b0) && n < budget) begin
            step();
            n++;
        end
        chk("wait_done_in_budget", 32'(n < budget), 32'd1);
        repeat (4) step();
    endtask

    task automatic clear_stats();
        re_cnt = 0;
        busy_cnt = 0;
        runs.delete();
    endtask

    initial begin
        reset = 1'b1; clk_enable = 1'b1; start = 1'b0; length = '0;
        for (int i = 0; i < 16; i++) mem[i] = 8'(i * 17);
        repeat (3) step();
        reset = 1'b0;
        repeat (2) step();
        chk("rst_tx", tx, 32'd1);
        chk("rst_busy", busy, 32'd0);
        chk("rst_done", done, 32'd0);
        chk("rst_addr", addr, 32'd0);

        // two data bytes, plus an ignored restart attempt while busy
        mem[0] = 8'hA5; mem[1] = 8'h3C;
        clear_stats();
        pulse_start(16'd2);
        repeat (20) step();
        length = 16'd5; start = 1'b1;
        step();
        start = 1'b0;
        wait_done(2000);
        chk("t1_done", done, 32'd1);
        chk("t1_addr", addr, 32'd2);
        chk("t1_re_cnt", 32'(re_cnt), 32'd2);
        chk("t1_busy_cycles", 32'(busy_cnt), 32'd648);

        // zero-length dump
        clear_stats();
        pulse_start(16'd0);
        wait_done(1000);
        chk("t2_done", done, 32'd1);
        chk("t2_addr", addr, 32'd0);
        chk("t2_re_cnt", 32'(re_cnt), 32'd0);
        chk("t2_busy_cycles", 32'(busy_cnt), 32'd324);

        // clk_enable toggling: every bit becomes 32 clocks wide
        mem[0] = 8'h81;
        clear_stats();
        tog = 1'b1;
        pulse_start(16'd1);
        wait_done(4000);
        tog = 1'b0;
        repeat (2) step();
        chk("t3_run_count", 32'(runs.size()), 32'd5);
        if (runs.size() == 5) begin
            chk("t3_run0", 32'(runs[0]), 32'd288);
            chk("t3_run1", 32'(runs[1]), 32'd32);
            chk("t3_run2", 32'(runs[2]), 32'd224);
            chk("t3_run3", 32'(runs[3]), 32'd32);
            chk("t3_run4", 32'(runs[4]), 32'd192);
        end
        chk("t3_re_cnt", 32'(re_cnt), 32'd1);
        chk("t3_addr", addr, 32'd1);

        // reset during the third bit of the header-low frame
        pulse_start(16'd1);
        repeat (200) step();
        chk("t4_pre_tx", tx, 32'd0);
        chk("t4_pre_busy", busy, 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("t4_rst_tx", tx, 32'd1);
        chk("t4_rst_busy", busy, 32'd0);
        chk("t4_rst_done", done, 32'd0);
        chk("t4_rst_addr", addr, 32'd0);
        mem[0] = 8'($urandom);
        pulse_start(16'd1);
        wait_done(1000);
        chk("t4_done", done, 32'd1);
        chk("t4_addr", addr, 32'd1);

        // four random bytes
        for (int i = 0; i < 4; i++) mem[i] = 8'($urandom);
        clear_stats();
        pulse_start(16'd4);
        wait_done(2000);
        chk("t5_done", done, 32'd1);
        chk("t5_addr", addr, 32'd4);
        chk("t5_re_cnt", 32'(re_cnt), 32'd4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
